// File: rtl/pipe_stage_regs_if.sv
// pipe_stage_regs_if: control inputs and per-stage state of the pipeline register bank
interface pipe_stage_regs_if #(parameter int CNT_W = 32);
  logic [31:0] pc_next, inst_f;
  logic regwen_d;
  logic stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic flush_id, flush_ex, flush_mem, flush_wb;
  logic [31:0] pc, inst_d, inst_ex, inst_mem, inst_wb;
  logic [31:0] pc_d, pc_ex, pc_mem, pc_wb;
  logic valid_d, valid_ex, valid_mem, valid_wb;
  logic regwen_ex, regwen_mem, regwen_wb;
  logic [CNT_W-1:0] retired_cnt, stall_cnt, flush_cnt;
  modport master (
    output pc_next, inst_f, regwen_d, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           flush_id, flush_ex, flush_mem, flush_wb,
    input  pc, inst_d, inst_ex, inst_mem, inst_wb, pc_d, pc_ex, pc_mem, pc_wb,
           valid_d, valid_ex, valid_mem, valid_wb, regwen_ex, regwen_mem, regwen_wb,
           retired_cnt, stall_cnt, flush_cnt
  );
  modport slave (
    input  pc_next, inst_f, regwen_d, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           flush_id, flush_ex, flush_mem, flush_wb,
    output pc, inst_d, inst_ex, inst_mem, inst_wb, pc_d, pc_ex, pc_mem, pc_wb,
           valid_d, valid_ex, valid_mem, valid_wb, regwen_ex, regwen_mem, regwen_wb,
           retired_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC and IF/ID..MEM/WB registers with flush-over-stall priority and saturating perf counters
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  pipe_stage_regs_if.slave bus
);
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.pc <= RESET_PC;
    else if (!bus.stall_if) bus.pc <= bus.pc_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.inst_d <= NOP_INST; bus.pc_d <= '0; bus.valid_d <= 1'b0;
    end else if (bus.flush_id) begin
      bus.inst_d <= NOP_INST; bus.pc_d <= '0; bus.valid_d <= 1'b0;
    end else if (!bus.stall_id) begin
      bus.inst_d <= bus.inst_f; bus.pc_d <= bus.pc; bus.valid_d <= 1'b1;
    end
  // a bubble in ID never carries a register write into EX
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.inst_ex <= NOP_INST; bus.pc_ex <= '0; bus.valid_ex <= 1'b0; bus.regwen_ex <= 1'b0;
    end else if (bus.flush_ex) begin
      bus.inst_ex <= NOP_INST; bus.pc_ex <= '0; bus.valid_ex <= 1'b0; bus.regwen_ex <= 1'b0;
    end else if (!bus.stall_ex) begin
      bus.inst_ex <= bus.inst_d; bus.pc_ex <= bus.pc_d; bus.valid_ex <= bus.valid_d;
      bus.regwen_ex <= bus.regwen_d & bus.valid_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.inst_mem <= NOP_INST; bus.pc_mem <= '0; bus.valid_mem <= 1'b0; bus.regwen_mem <= 1'b0;
    end else if (bus.flush_mem) begin
      bus.inst_mem <= NOP_INST; bus.pc_mem <= '0; bus.valid_mem <= 1'b0; bus.regwen_mem <= 1'b0;
    end else if (!bus.stall_mem) begin
      bus.inst_mem <= bus.inst_ex; bus.pc_mem <= bus.pc_ex; bus.valid_mem <= bus.valid_ex;
      bus.regwen_mem <= bus.regwen_ex;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.inst_wb <= NOP_INST; bus.pc_wb <= '0; bus.valid_wb <= 1'b0; bus.regwen_wb <= 1'b0;
    end else if (bus.flush_wb) begin
      bus.inst_wb <= NOP_INST; bus.pc_wb <= '0; bus.valid_wb <= 1'b0; bus.regwen_wb <= 1'b0;
    end else if (!bus.stall_wb) begin
      bus.inst_wb <= bus.inst_mem; bus.pc_wb <= bus.pc_mem; bus.valid_wb <= bus.valid_mem;
      bus.regwen_wb <= bus.regwen_mem;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.retired_cnt <= '0; bus.stall_cnt <= '0; bus.flush_cnt <= '0;
    end else begin
      if (bus.valid_wb && !bus.stall_wb && !(&bus.retired_cnt)) bus.retired_cnt <= bus.retired_cnt + CNT_W'(1);
      if (bus.stall_if && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (bus.flush_id && !(&bus.flush_cnt)) bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed checks of streaming, stalls, flushes, saturation and async reset
module tb_pipe_stage_regs;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] ADD = 32'h0020_8133;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  pipe_stage_regs_if #(.CNT_W(32)) a ();
  pipe_stage_regs_if #(.CNT_W(4)) b ();
  pipe_stage_regs #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(a));
  pipe_stage_regs #(.CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
  assign b.pc_next = a.pc_next;
  assign b.inst_f = a.inst_f;
  assign b.regwen_d = a.regwen_d;
  assign b.stall_if = a.stall_if;
  assign b.stall_id = a.stall_id;
  assign b.stall_ex = a.stall_ex;
  assign b.stall_mem = a.stall_mem;
  assign b.stall_wb = a.stall_wb;
  assign b.flush_id = a.flush_id;
  assign b.flush_ex = a.flush_ex;
  assign b.flush_mem = a.flush_mem;
  assign b.flush_wb = a.flush_wb;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    a.pc_next = a.pc + 32'd4;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (a.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", a.pc, 32'h0); end
    checks++; if (a.inst_d !== NOP) begin errors++; $display("FAIL rst_inst_d got %h exp %h", a.inst_d, NOP); end
    checks++; if (a.inst_wb !== NOP) begin errors++; $display("FAIL rst_inst_wb got %h exp %h", a.inst_wb, NOP); end
    checks++; if (a.valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid_d got %b exp 0", a.valid_d); end
    checks++; if (a.valid_wb !== 1'b0) begin errors++; $display("FAIL rst_valid_wb got %b exp 0", a.valid_wb); end
    checks++; if (a.regwen_wb !== 1'b0) begin errors++; $display("FAIL rst_regwen_wb got %b exp 0", a.regwen_wb); end
    checks++; if (a.retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_retired got %0d exp 0", a.retired_cnt); end
    checks++; if (a.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", a.stall_cnt); end
    checks++; if (a.flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_flush got %0d exp 0", a.flush_cnt); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    tick();
    checks++; if (a.pc !== 32'h4) begin errors++; $display("FAIL stream_pc got %h exp %h", a.pc, 32'h4); end
    checks++; if (a.inst_d !== ADDI) begin errors++; $display("FAIL stream_inst_d got %h exp %h", a.inst_d, ADDI); end
    checks++; if (a.pc_d !== 32'h0) begin errors++; $display("FAIL stream_pc_d got %h exp 0", a.pc_d); end
    checks++; if (a.valid_d !== 1'b1) begin errors++; $display("FAIL stream_valid_d got %b exp 1", a.valid_d); end
    checks++; if (a.valid_ex !== 1'b0) begin errors++; $display("FAIL stream_valid_ex got %b exp 0", a.valid_ex); end
    repeat (3) tick();
    checks++; if (a.inst_wb !== ADDI) begin errors++; $display("FAIL stream_inst_wb got %h exp %h", a.inst_wb, ADDI); end
    checks++; if (a.pc_wb !== 32'h0) begin errors++; $display("FAIL stream_pc_wb got %h exp 0", a.pc_wb); end
    checks++; if (a.valid_wb !== 1'b1) begin errors++; $display("FAIL stream_valid_wb got %b exp 1", a.valid_wb); end
    checks++; if (a.regwen_wb !== 1'b1) begin errors++; $display("FAIL stream_regwen_wb got %b exp 1", a.regwen_wb); end
    checks++; if (a.retired_cnt !== 32'd0) begin errors++; $display("FAIL stream_ret0 got %0d exp 0", a.retired_cnt); end
    tick();
    checks++; if (a.retired_cnt !== 32'd1) begin errors++; $display("FAIL stream_ret1 got %0d exp 1", a.retired_cnt); end
    checks++; if (a.pc_wb !== 32'h4) begin errors++; $display("FAIL stream_pc_wb2 got %h exp %h", a.pc_wb, 32'h4); end
    tick();
    checks++; if (a.retired_cnt !== 32'd2) begin errors++; $display("FAIL stream_ret2 got %0d exp 2", a.retired_cnt); end
  endtask

  task automatic test_raw_stall();
    a.inst_f = ADD;
    tick();
    a.stall_if = 1'b1; a.stall_id = 1'b1; a.flush_ex = 1'b1;
    repeat (2) tick();
    a.stall_if = 1'b0; a.stall_id = 1'b0; a.flush_ex = 1'b0;
    checks++; if (a.pc !== 32'd28) begin errors++; $display("FAIL raw_pc got %0d exp 28", a.pc); end
    checks++; if (a.inst_d !== ADD) begin errors++; $display("FAIL raw_inst_d got %h exp %h", a.inst_d, ADD); end
    checks++; if (a.pc_d !== 32'd24) begin errors++; $display("FAIL raw_pc_d got %0d exp 24", a.pc_d); end
    checks++; if (a.inst_ex !== NOP) begin errors++; $display("FAIL raw_inst_ex got %h exp %h", a.inst_ex, NOP); end
    checks++; if (a.valid_ex !== 1'b0) begin errors++; $display("FAIL raw_valid_ex got %b exp 0", a.valid_ex); end
    checks++; if (a.regwen_ex !== 1'b0) begin errors++; $display("FAIL raw_regwen_ex got %b exp 0", a.regwen_ex); end
    checks++; if (a.stall_cnt !== 32'd2) begin errors++; $display("FAIL raw_stall_cnt got %0d exp 2", a.stall_cnt); end
    checks++; if (a.valid_mem !== 1'b0) begin errors++; $display("FAIL raw_valid_mem got %b exp 0", a.valid_mem); end
    checks++; if (a.pc_wb !== 32'd20) begin errors++; $display("FAIL raw_pc_wb got %0d exp 20", a.pc_wb); end
    checks++; if (a.retired_cnt !== 32'd5) begin errors++; $display("FAIL raw_retired got %0d exp 5", a.retired_cnt); end
  endtask

  task automatic test_redirect();
    tick();
    a.flush_id = 1'b1; a.flush_ex = 1'b1;
    tick();
    a.flush_id = 1'b0; a.flush_ex = 1'b0;
    checks++; if (a.inst_d !== NOP) begin errors++; $display("FAIL br_inst_d got %h exp %h", a.inst_d, NOP); end
    checks++; if (a.valid_d !== 1'b0) begin errors++; $display("FAIL br_valid_d got %b exp 0", a.valid_d); end
    checks++; if (a.pc_d !== 32'd0) begin errors++; $display("FAIL br_pc_d got %0d exp 0", a.pc_d); end
    checks++; if (a.inst_ex !== NOP) begin errors++; $display("FAIL br_inst_ex got %h exp %h", a.inst_ex, NOP); end
    checks++; if (a.valid_ex !== 1'b0) begin errors++; $display("FAIL br_valid_ex got %b exp 0", a.valid_ex); end
    checks++; if (a.pc_mem !== 32'd24) begin errors++; $display("FAIL br_pc_mem got %0d exp 24", a.pc_mem); end
    checks++; if (a.inst_mem !== ADD) begin errors++; $display("FAIL br_inst_mem got %h exp %h", a.inst_mem, ADD); end
    checks++; if (a.regwen_mem !== 1'b1) begin errors++; $display("FAIL br_regwen_mem got %b exp 1", a.regwen_mem); end
    checks++; if (a.flush_cnt !== 32'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", a.flush_cnt); end
    checks++; if (a.retired_cnt !== 32'd6) begin errors++; $display("FAIL br_retired got %0d exp 6", a.retired_cnt); end
  endtask

  task automatic test_collision();
    tick();
    checks++; if (a.valid_d !== 1'b1) begin errors++; $display("FAIL col_pre_valid got %b exp 1", a.valid_d); end
    a.stall_id = 1'b1; a.flush_id = 1'b1;
    tick();
    a.stall_id = 1'b0; a.flush_id = 1'b0;
    checks++; if (a.valid_d !== 1'b0) begin errors++; $display("FAIL col_valid_d got %b exp 0", a.valid_d); end
    checks++; if (a.inst_d !== NOP) begin errors++; $display("FAIL col_inst_d got %h exp %h", a.inst_d, NOP); end
    checks++; if (a.pc_ex !== 32'd36) begin errors++; $display("FAIL col_pc_ex got %0d exp 36", a.pc_ex); end
    checks++; if (a.flush_cnt !== 32'd2) begin errors++; $display("FAIL col_flush_cnt got %0d exp 2", a.flush_cnt); end
  endtask

  task automatic test_wb_stall();
    repeat (2) tick();
    checks++; if (a.pc_wb !== 32'd36 || a.valid_wb !== 1'b1) begin errors++; $display("FAIL wbs_pre got pc %0d v %b exp pc 36 v 1", a.pc_wb, a.valid_wb); end
    checks++; if (a.retired_cnt !== 32'd7) begin errors++; $display("FAIL wbs_pre_ret got %0d exp 7", a.retired_cnt); end
    a.stall_wb = 1'b1;
    tick();
    a.stall_wb = 1'b0;
    checks++; if (a.pc_wb !== 32'd36) begin errors++; $display("FAIL wbs_pc_wb got %0d exp 36", a.pc_wb); end
    checks++; if (a.inst_wb !== ADD) begin errors++; $display("FAIL wbs_inst_wb got %h exp %h", a.inst_wb, ADD); end
    checks++; if (a.retired_cnt !== 32'd7) begin errors++; $display("FAIL wbs_retired got %0d exp 7", a.retired_cnt); end
    tick();
    checks++; if (a.retired_cnt !== 32'd8) begin errors++; $display("FAIL wbs_retired2 got %0d exp 8", a.retired_cnt); end
    checks++; if (a.pc_wb !== 32'd44) begin errors++; $display("FAIL wbs_pc_wb2 got %0d exp 44", a.pc_wb); end
  endtask

  task automatic test_saturation();
    repeat (20) tick();
    checks++; if (a.retired_cnt !== 32'd28) begin errors++; $display("FAIL sat_wide got %0d exp 28", a.retired_cnt); end
    checks++; if (b.retired_cnt !== 4'hF) begin errors++; $display("FAIL sat_narrow got %h exp f", b.retired_cnt); end
    checks++; if (b.stall_cnt !== 4'd2) begin errors++; $display("FAIL sat_stall got %0d exp 2", b.stall_cnt); end
    checks++; if (b.flush_cnt !== 4'd2) begin errors++; $display("FAIL sat_flush got %0d exp 2", b.flush_cnt); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    checks++; if (a.pc !== 32'h0) begin errors++; $display("FAIL ar_pc got %h exp 0", a.pc); end
    checks++; if (a.valid_wb !== 1'b0) begin errors++; $display("FAIL ar_valid_wb got %b exp 0", a.valid_wb); end
    checks++; if (a.inst_ex !== NOP) begin errors++; $display("FAIL ar_inst_ex got %h exp %h", a.inst_ex, NOP); end
    checks++; if (a.pc_mem !== 32'h0) begin errors++; $display("FAIL ar_pc_mem got %h exp 0", a.pc_mem); end
    checks++; if (a.retired_cnt !== 32'd0) begin errors++; $display("FAIL ar_retired got %0d exp 0", a.retired_cnt); end
    checks++; if (b.retired_cnt !== 4'd0) begin errors++; $display("FAIL ar_retired_b got %0d exp 0", b.retired_cnt); end
    tick();
    checks++; if (a.valid_d !== 1'b0) begin errors++; $display("FAIL ar_hold_valid_d got %b exp 0", a.valid_d); end
    rst = 1'b0;
    tick();
    checks++; if (a.valid_d !== 1'b1 || a.pc_d !== 32'h0) begin errors++; $display("FAIL ar_release got v %b pc %h exp v 1 pc 0", a.valid_d, a.pc_d); end
  endtask

  initial begin
    a.pc_next = 32'h0; a.inst_f = ADDI; a.regwen_d = 1'b1;
    a.stall_if = 1'b0; a.stall_id = 1'b0; a.stall_ex = 1'b0; a.stall_mem = 1'b0; a.stall_wb = 1'b0;
    a.flush_id = 1'b0; a.flush_ex = 1'b0; a.flush_mem = 1'b0; a.flush_wb = 1'b0;
    test_reset();
    test_stream();
    test_raw_stall();
    test_redirect();
    test_collision();
    test_wb_stall();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
